// File: rtl/axonerve_kvs_stream_alu_pkg.sv
// Shared definitions for the KVS stream ALU: mode encodings and the per-lane operation.
// Lanes up to 64 bits are handled by computing in 65 bits and masking to the lane width.
package axonerve_kvs_stream_alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_PASS = 2'b11
  } alu_mode_e;

  // Returns {sat_flag, result}; only the low lw bits of the result are meaningful.
  function automatic logic [64:0] lane_op(input alu_mode_e mode, input logic [63:0] lane,
                                          input logic [63:0] cst, input logic [6:0] lw);
    logic [64:0] mask;
    logic [64:0] a;
    logic [64:0] b;
    logic [64:0] sum;
    logic [64:0] res;
    logic        sat;
    mask = (65'd1 << lw) - 65'd1;
    a    = {1'b0, lane} & mask;
    b    = {1'b0, cst} & mask;
    sum  = a + b;
    sat  = 1'b0;
    case (mode)
      MODE_ADD: res = sum & mask;
      MODE_SUB: res = (a - b) & mask;
      MODE_SAT: begin
        sat = sum[lw];
        res = sat ? mask : sum;
      end
      default:  res = a;
    endcase
    return {sat, res[63:0]};
  endfunction

endpackage

// File: rtl/axonerve_kvs_axis_fifo2.sv
// Two-entry output buffer; o_dat is valid in the same cycle as o_vld (no read latency).
// Push is accepted when not full or when a pop happens in the same cycle; pop is ignored when empty.
module axonerve_kvs_axis_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_occ;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = i_pop & (r_occ != 2'd0);
  assign w_do_push = i_push & ((r_occ != 2'd2) | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // When full, a simultaneous push overwrites the slot being popped this cycle.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

  assign o_vld = (r_occ != 2'd0);
  assign o_dat = r_mem[r_rptr];
  assign o_occ = r_occ;

endmodule

// File: rtl/axonerve_kvs_stream_alu.sv
// Lane-wise AXIS ALU (add/sub/sat-add/pass with a per-packet constant); 2-cycle latency into an empty buffer.
// s_axis_tready depends only on registered occupancy, never on m_axis_tready. Counters need AXONERVE_KVS_STREAM_ALU_STATS_EN.
module axonerve_kvs_stream_alu
  import axonerve_kvs_stream_alu_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_STAT_WIDTH       = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
  input  logic [1:0]                      ctrl_mode,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_STAT_WIDTH-1:0]         stat_pkt_count,
  output logic [C_STAT_WIDTH-1:0]         stat_beat_count,
  output logic [C_STAT_WIDTH-1:0]         stat_sat_count
);

  localparam int NL = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int PW = C_AXIS_TDATA_WIDTH + KW + 1;

  logic                          r_in_pkt;
  logic [C_LANE_WIDTH-1:0]       r_op_const;
  alu_mode_e                     r_op_mode;
  logic                          r_s1_vld;
  logic [C_AXIS_TDATA_WIDTH-1:0] r_s1_dat;
  logic [KW-1:0]                 r_s1_keep;
  logic                          r_s1_last;

  logic                          w_in_hs;
  logic [C_LANE_WIDTH-1:0]       w_const;
  alu_mode_e                     w_mode;
  logic [C_AXIS_TDATA_WIDTH-1:0] w_res;
  logic [NL-1:0]                 w_sat;
  logic                          w_pop;
  logic                          w_s1_move;
  logic [1:0]                    w_occ;
  logic [2:0]                    w_fill;
  logic [PW-1:0]                 w_fifo_dat;

  assign w_in_hs = s_axis_tvalid & s_axis_tready;
  // The first beat of a packet uses the live ctrl inputs, later beats the latched copy.
  assign w_const = r_in_pkt ? r_op_const : ctrl_constant;
  assign w_mode  = r_in_pkt ? r_op_mode : alu_mode_e'(ctrl_mode);

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [64:0] w_op;
    assign w_op = lane_op(w_mode, 64'(s_axis_tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH]),
                          64'(w_const), 7'(C_LANE_WIDTH));
    assign w_res[i*C_LANE_WIDTH +: C_LANE_WIDTH] = w_op[C_LANE_WIDTH-1:0];
    assign w_sat[i] = w_op[64];
    if (C_LANE_WIDTH < 64) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_op[63:C_LANE_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_in_pkt   <= 1'b0;
      r_op_const <= '0;
      r_op_mode  <= MODE_ADD;
    end else if (w_in_hs) begin
      if (!r_in_pkt) begin
        r_op_const <= ctrl_constant;
        r_op_mode  <= alu_mode_e'(ctrl_mode);
      end
      r_in_pkt <= ~s_axis_tlast;
    end
  end

  assign w_pop     = m_axis_tvalid & m_axis_tready;
  assign w_s1_move = r_s1_vld & ((w_occ != 2'd2) | w_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_vld  <= 1'b0;
      r_s1_dat  <= '0;
      r_s1_keep <= '0;
      r_s1_last <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_s1_vld  <= 1'b1;
        r_s1_dat  <= w_res;
        r_s1_keep <= s_axis_tkeep;
        r_s1_last <= s_axis_tlast;
      end else if (w_s1_move) begin
        r_s1_vld  <= 1'b0;
      end
    end
  end

  // Three beats can be in flight (S1 plus two buffered), so ready never waits on the sink.
  assign w_fill        = {1'b0, w_occ} + {2'b0, r_s1_vld};
  assign s_axis_tready = aresetn & (w_fill < 3'd3);

  axonerve_kvs_axis_fifo2 #(
    .W (PW)
  ) u_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_push (w_s1_move),
    .i_dat  ({r_s1_dat, r_s1_keep, r_s1_last}),
    .i_pop  (w_pop),
    .o_vld  (m_axis_tvalid),
    .o_dat  (w_fifo_dat),
    .o_occ  (w_occ)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = w_fifo_dat;

`ifdef AXONERVE_KVS_STREAM_ALU_STATS_EN
  logic                    r_s1_sat;
  logic [C_STAT_WIDTH-1:0] r_pkt_cnt;
  logic [C_STAT_WIDTH-1:0] r_beat_cnt;
  logic [C_STAT_WIDTH-1:0] r_sat_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_sat   <= 1'b0;
      r_pkt_cnt  <= '0;
      r_beat_cnt <= '0;
      r_sat_cnt  <= '0;
    end else begin
      if (w_in_hs) begin
        r_s1_sat   <= |w_sat;
        r_beat_cnt <= r_beat_cnt + C_STAT_WIDTH'(1);
        if (s_axis_tlast) r_pkt_cnt <= r_pkt_cnt + C_STAT_WIDTH'(1);
      end
      if (w_s1_move && r_s1_sat) r_sat_cnt <= r_sat_cnt + C_STAT_WIDTH'(1);
    end
  end

  assign stat_pkt_count  = r_pkt_cnt;
  assign stat_beat_count = r_beat_cnt;
  assign stat_sat_count  = r_sat_cnt;
`else
  logic w_unused_sat;
  assign w_unused_sat    = ^w_sat;
  assign stat_pkt_count  = '0;
  assign stat_beat_count = '0;
  assign stat_sat_count  = '0;
`endif

endmodule

// File: tb/tb_axonerve_kvs_stream_alu.sv
// Bench for axonerve_kvs_stream_alu (64-bit bus, two 32-bit lanes) with a scoreboard reference model.
// Statistic expectations follow AXONERVE_KVS_STREAM_ALU_STATS_EN.
module tb_axonerve_kvs_stream_alu;

  localparam int DW = 64;
  localparam int LW = 32;
  localparam int KW = 8;
  localparam int SW = 32;
`ifdef AXONERVE_KVS_STREAM_ALU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          aclk;
  logic          aresetn;
  logic [LW-1:0] ctrl_constant;
  logic [1:0]    ctrl_mode;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [SW-1:0] stat_pkt_count;
  logic [SW-1:0] stat_beat_count;
  logic [SW-1:0] stat_sat_count;

  axonerve_kvs_stream_alu #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_LANE_WIDTH       (LW),
    .C_STAT_WIDTH       (SW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .ctrl_constant   (ctrl_constant),
    .ctrl_mode       (ctrl_mode),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tkeep    (s_axis_tkeep),
    .s_axis_tlast    (s_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tkeep    (m_axis_tkeep),
    .m_axis_tlast    (m_axis_tlast),
    .stat_pkt_count  (stat_pkt_count),
    .stat_beat_count (stat_beat_count),
    .stat_sat_count  (stat_sat_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
    int            acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  bit          lat_on = 1'b0;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat;
  bit          m_in_pkt = 1'b0;
  logic [31:0] m_c;
  logic [1:0]  m_m;
  int unsigned m_beats = 0;
  int unsigned m_pkts = 0;
  int unsigned m_sats = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference lane arithmetic straight from the operation definitions.
  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic [31:0] c,
                                             input logic [1:0] m, output bit sat);
    logic [DW-1:0] res;
    logic [63:0]   a;
    logic [63:0]   r;
    logic [63:0]   cc;
    sat = 1'b0;
    res = '0;
    cc  = {32'd0, c};
    for (int i = 0; i < DW / LW; i++) begin
      a = {32'd0, d[32*i +: 32]};
      case (m)
        2'd0: r = (a + cc) % 64'h1_0000_0000;
        2'd1: r = (a + 64'h1_0000_0000 - cc) % 64'h1_0000_0000;
        2'd2: begin
          r = a + cc;
          if (r > 64'hFFFF_FFFF) begin
            r   = 64'hFFFF_FFFF;
            sat = 1'b1;
          end
        end
        default: r = a;
      endcase
      res[32*i +: 32] = r[31:0];
    end
    return res;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: acts on the handshakes that complete at the next rising edge.
  always @(negedge aclk) begin
    exp_t e;
    bit   sat;
    check_eq("s_tready", 64'(s_axis_tready), 64'(aresetn && (q.size() < 3)));
    if (!aresetn) begin
      q.delete();
      m_in_pkt   = 1'b0;
      m_beats    = 0;
      m_pkts     = 0;
      m_sats     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("m_hold_vld", 64'(m_axis_tvalid), 64'd1);
        check_eq("m_hold_dat", m_axis_tdata, prev_dat);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_dat   = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check_eq("out_data", m_axis_tdata, e.dat);
          check_eq("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
          check_eq("out_last", 64'(m_axis_tlast), 64'(e.last));
          if (lat_on) check_eq("latency", 64'(cyc - e.acc), 64'd2);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (!m_in_pkt) begin
          m_c = ctrl_constant;
          m_m = ctrl_mode;
        end
        m_in_pkt = !s_axis_tlast;
        e.dat  = ref_beat(s_axis_tdata, m_c, m_m, sat);
        e.keep = s_axis_tkeep;
        e.last = s_axis_tlast;
        e.acc  = cyc;
        q.push_back(e);
        m_beats++;
        if (s_axis_tlast) m_pkts++;
        if (sat) m_sats++;
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [31:0] c, input logic [1:0] m);
    bit ok;
    int t;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    ctrl_constant = c;
    ctrl_mode     = m;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 300) begin
      @(negedge aclk);
      ok = s_axis_tready;
      @(posedge aclk);
      #1;
      t++;
    end
    check_eq("send_accept", 64'(ok), 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(posedge aclk);
      t++;
    end
    repeat (2) @(posedge aclk);
    #1;
    check_eq("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_beats"}, 64'(stat_beat_count), STATS ? 64'(m_beats) : 64'd0);
    check_eq({tag, "_pkts"},  64'(stat_pkt_count),  STATS ? 64'(m_pkts)  : 64'd0);
    check_eq({tag, "_sats"},  64'(stat_sat_count),  STATS ? 64'(m_sats)  : 64'd0);
  endtask

  function automatic logic [31:0] rnd_lane();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    ctrl_constant = '0;
    ctrl_mode     = 2'd0;
    #1;
    check_eq("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check_eq("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_stats("rst");
    #21;
    aresetn = 1'b1;
    #1;
    check_eq("rel_s_tready", 64'(s_axis_tready), 64'd1);
    @(posedge aclk);
    #1;

    // 4-beat add packet, constant 5; later beats carry ignored ctrl values.
    lat_on = 1'b1;
    send_beat(64'hFFFF_FFFE_FFFF_FFFE, 8'hFF, 1'b0, 32'd5, 2'd0);
    for (int i = 0; i < 3; i++)
      send_beat({rnd_lane(), rnd_lane()}, 8'hFF, (i == 2), 32'($urandom), 2'($urandom_range(0, 3)));
    drain();

    // Sub packet with a mid-packet switch to add that must be ignored.
    send_beat(64'd0, 8'hFF, 1'b0, 32'd1, 2'd1);
    send_beat({rnd_lane(), rnd_lane()}, 8'h0F, 1'b0, 32'd7, 2'd0);
    send_beat(64'd0, 8'hFF, 1'b1, 32'd9, 2'd0);
    drain();

    // Saturating add: one lane saturates, one does not.
    send_beat({32'h0000_0020, 32'hFFFF_FFF8}, 8'hFF, 1'b1, 32'h10, 2'd2);
    drain();
    check_stats("sat");

    // Single-beat packets alternating the constant.
    for (int i = 0; i < 8; i++)
      send_beat({rnd_lane(), rnd_lane()}, 8'($urandom), 1'b1, (i % 2 == 1) ? 32'h1000 : 32'h3, 2'd0);
    drain();
    check_stats("single");

    // Random traffic under random sink backpressure.
    lat_on   = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      send_beat({rnd_lane(), rnd_lane()}, 8'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255)),
                2'($urandom_range(0, 3)));
    end
    drain();
    check_stats("random");

    // Fill the pipeline mid-packet, then reset.
    rdy_mode = 1;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 3; i++)
      send_beat({rnd_lane(), rnd_lane()}, 8'hFF, 1'b0, 32'h55, 2'd0);
    check_eq("full_s_tready", 64'(s_axis_tready), 64'd0);
    check_eq("full_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check_eq("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    check_eq("mid_rst_beats", 64'(stat_beat_count), 64'd0);
    check_eq("mid_rst_pkts", 64'(stat_pkt_count), 64'd0);
    check_eq("mid_rst_sats", 64'(stat_sat_count), 64'd0);
    #10;
    aresetn  = 1'b1;
    rdy_mode = 0;
    @(posedge aclk);
    #1;
    lat_on = 1'b1;
    send_beat({32'h0000_0100, 32'h0000_0000}, 8'hFF, 1'b1, 32'h77, 2'd1);
    drain();
    check_stats("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
